// File: rtl/ftf_pkg.sv
// rtl/ftf_pkg.sv - Fibonacci constants and stage token type for the FTF encoder
package ftf_pkg;

    function automatic int unsigned fns(input int k);
        int unsigned a;
        int unsigned b;
        int unsigned t;
        a = 1;
        b = 1;
        for (int j = 3; j <= k; j++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    function automatic int unsigned ftf_max_val(input int n);
        return fns(n + 2) - 1;
    endfunction

    function automatic int ftf_data_w(input int n);
        return $clog2(fns(n + 2));
    endfunction

    // Compare threshold for bit i; the MSB and odd bits look one Fibonacci step higher.
    function automatic int unsigned ftf_thresh(input int n, input int i);
        if (i == n - 1) return fns(n + 1);
        if (i % 2 == 1) return fns(i + 2);
        return fns(i + 1);
    endfunction

    localparam int FTF_CODE_MAX_W = 32;
    localparam int FTF_REM_W      = ftf_data_w(FTF_CODE_MAX_W);

    typedef struct packed {
        logic                      valid;
        logic [FTF_REM_W-1:0]      rem;
        logic [FTF_CODE_MAX_W-1:0] code;
        logic                      err;
    } ftf_tok_t;

endpackage

// File: rtl/ftf_enc_slice.sv
// rtl/ftf_enc_slice.sv - resolves code bits HI down to LO from a running remainder
module ftf_enc_slice
    import ftf_pkg::*;
#(
    parameter int CODE_W = 16,
    parameter int HI     = 15,
    parameter int LO     = 8
) (
    input  logic [FTF_REM_W-1:0]      rem_in,
    input  logic [FTF_CODE_MAX_W-1:0] code_in,
    output logic [FTF_REM_W-1:0]      rem_out,
    output logic [FTF_CODE_MAX_W-1:0] code_out
);

    // An empty range (HI < LO) makes this slice a pass-through.
    always_comb begin
        rem_out  = rem_in;
        code_out = code_in;
        for (int i = HI; i >= LO; i--) begin
            if (rem_out >= FTF_REM_W'(ftf_thresh(CODE_W, i))) begin
                code_out[i] = 1'b1;
                rem_out     = rem_out - FTF_REM_W'(fns(i + 1));
            end
        end
    end

endmodule

// File: rtl/ftf_encoder_pipe.sv
// rtl/ftf_encoder_pipe.sv - pipelined binary to FTF Fibonacci codeword encoder
module ftf_encoder_pipe
    import ftf_pkg::*;
#(
    parameter int CODE_W = 16,
    parameter int STAGES = 2
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ftf_data_w(CODE_W)-1:0]  data_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CODE_W-1:0]              code_out,
    output logic                           range_err
);

    localparam int DATA_W = ftf_data_w(CODE_W);
    localparam int PER    = (CODE_W + STAGES - 1) / STAGES;

    ftf_tok_t tok_q [STAGES];
    ftf_tok_t tok_d [STAGES];

    logic [STAGES:0]           load;
    logic                      src_err;
    logic                      stg_vld      [STAGES];
    logic                      stg_err      [STAGES];
    logic [FTF_REM_W-1:0]      stg_rem_in   [STAGES];
    logic [FTF_CODE_MAX_W-1:0] stg_code_in  [STAGES];
    logic [FTF_REM_W-1:0]      stg_rem_out  [STAGES];
    logic [FTF_CODE_MAX_W-1:0] stg_code_out [STAGES];

    // Out-of-range values are clamped so the token encodes to all ones.
    always_comb begin
        src_err        = data_in > DATA_W'(ftf_max_val(CODE_W));
        stg_vld[0]     = in_valid;
        stg_err[0]     = src_err;
        stg_rem_in[0]  = src_err ? FTF_REM_W'(ftf_max_val(CODE_W)) : FTF_REM_W'(data_in);
        stg_code_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            stg_vld[k]     = tok_q[k-1].valid;
            stg_err[k]     = tok_q[k-1].err;
            stg_rem_in[k]  = tok_q[k-1].rem;
            stg_code_in[k] = tok_q[k-1].code;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int HI = CODE_W - 1 - k * PER;
        localparam int LO = (HI - PER + 1 > 0) ? HI - PER + 1 : 0;

        ftf_enc_slice #(
            .CODE_W (CODE_W),
            .HI     (HI),
            .LO     (LO)
        ) u_slice (
            .rem_in   (stg_rem_in[k]),
            .code_in  (stg_code_in[k]),
            .rem_out  (stg_rem_out[k]),
            .code_out (stg_code_out[k])
        );
    end

    // load[k]: stage k takes a new token (or a bubble) at the next edge.
    always_comb begin
        load[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            load[k] = !tok_q[k].valid || load[k+1];
        end
        for (int k = 0; k < STAGES; k++) begin
            tok_d[k] = tok_q[k];
            if (load[k]) begin
                tok_d[k] = '0;
                if (stg_vld[k]) begin
                    tok_d[k].valid = 1'b1;
                    tok_d[k].rem   = stg_rem_out[k];
                    tok_d[k].code  = stg_code_out[k];
                    tok_d[k].err   = stg_err[k];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < STAGES; k++) begin
            if (!reset_n) begin
                tok_q[k] <= '0;
            end else begin
                tok_q[k] <= tok_d[k];
            end
        end
    end

    assign in_ready  = reset_n && load[0];
    assign out_valid = tok_q[STAGES-1].valid;
    assign code_out  = tok_q[STAGES-1].code[CODE_W-1:0];
    assign range_err = tok_q[STAGES-1].err;

    logic unused_tail;
    assign unused_tail = ^{tok_q[STAGES-1].rem, tok_q[STAGES-1].code};

endmodule

// File: tb/tb_ftf_encoder_pipe.sv
// tb/tb_ftf_encoder_pipe.sv - self-checking bench for ftf_encoder_pipe
module tb_ftf_encoder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv4, ir4, ov4, or4, err4;
    logic [2:0]  din4;
    logic [3:0]  code4;
    logic        iv, ir, ov, ordy, rerr;
    logic [11:0] din;
    logic [15:0] code;

    int n_tests = 0;
    int n_fail  = 0;
    int fibt [0:24];

    typedef struct {
        logic [11:0] din;
        logic [15:0] code;
        logic        err;
    } vec_t;

    vec_t tab4  [8];
    vec_t tab16 [9];
    int   bp_vals [6] = '{10, 20, 30, 40, 50, 60};

    ftf_encoder_pipe #(.CODE_W(4), .STAGES(2)) u_d4 (
        .clock(clk), .reset_n(rst_n), .in_valid(iv4), .in_ready(ir4), .data_in(din4),
        .out_valid(ov4), .out_ready(or4), .code_out(code4), .range_err(err4)
    );

    ftf_encoder_pipe #(.CODE_W(16), .STAGES(4)) u_d16 (
        .clock(clk), .reset_n(rst_n), .in_valid(iv), .in_ready(ir), .data_in(din),
        .out_valid(ov), .out_ready(ordy), .code_out(code), .range_err(rerr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int weight(input logic [15:0] c);
        int s = 0;
        for (int i = 0; i < 16; i++) if (c[i]) s += fibt[i+1];
        return s;
    endfunction

    task automatic stream16(input int n, input int p_in, input int p_out, input bit sweep);
        int q[$];
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int e;
        while (got < n && cyc < 6 * n + 200) begin
            @(negedge clk);
            iv   = (sent < n) && ($urandom_range(99) < p_in);
            din  = sweep ? 12'(sent) : 12'($urandom_range(0, 2700));
            ordy = ($urandom_range(99) < p_out);
            #1;
            if (iv && ir) begin
                q.push_back(int'(din));
                sent++;
            end
            if (ov && ordy) begin
                if (q.size() == 0) begin
                    chk("spurious_out", ov, 0);
                end else begin
                    e = q.pop_front();
                    got++;
                    if (e > 2583) begin
                        chk("oor_code", code, 16'hFFFF);
                        chk("oor_err", rerr, 1);
                    end else begin
                        chk("code_sum", weight(code), e);
                        chk("code_err", rerr, 0);
                    end
                end
            end
            cyc++;
        end
        @(negedge clk);
        iv   = 1'b0;
        ordy = 1'b1;
        chk("tokens_out", got, n);
    endtask

    initial begin
        fibt[0] = 0;
        fibt[1] = 1;
        for (int i = 2; i <= 24; i++) fibt[i] = fibt[i-1] + fibt[i-2];

        tab4[0] = '{12'd0, 16'h0, 1'b0};
        tab4[1] = '{12'd3, 16'h5, 1'b0};
        tab4[2] = '{12'd4, 16'h7, 1'b0};
        tab4[3] = '{12'd5, 16'hC, 1'b0};
        tab4[4] = '{12'd7, 16'hF, 1'b0};
        tab4[5] = '{12'd1, 16'h1, 1'b0};
        tab4[6] = '{12'd2, 16'h4, 1'b0};
        tab4[7] = '{12'd6, 16'hD, 1'b0};

        tab16[0] = '{12'd0,    16'h0000, 1'b0};
        tab16[1] = '{12'd2583, 16'hFFFF, 1'b0};
        tab16[2] = '{12'd1597, 16'hC000, 1'b0};
        tab16[3] = '{12'd2584, 16'hFFFF, 1'b1};
        tab16[4] = '{12'd4095, 16'hFFFF, 1'b1};
        tab16[5] = '{12'd1,    16'h0001, 1'b0};
        tab16[6] = '{12'd2,    16'h0004, 1'b0};
        tab16[7] = '{12'd3,    16'h0005, 1'b0};
        tab16[8] = '{12'd987,  16'h5555, 1'b0};

        rst_n = 1'b0;
        iv4 = 1'b0; din4 = '0; or4 = 1'b1;
        iv  = 1'b0; din  = '0; ordy = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready16", ir, 0);
        chk("rst_in_ready4", ir4, 0);
        chk("rst_out_valid", ov, 0);
        chk("rst_code", code, 0);
        chk("rst_err", rerr, 0);
        chk("rst_out_valid4", ov4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready16", ir, 1);
        chk("post_rst_in_ready4", ir4, 1);

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            iv4 = (c < 8);
            if (c < 8) din4 = tab4[c].din[2:0];
            #1;
            if (c < 8) chk("d4_in_ready", ir4, 1);
            if (c >= 2) begin
                chk("d4_out_valid", ov4, 1);
                chk("d4_code", code4, tab4[c-2].code);
                chk("d4_err", err4, tab4[c-2].err);
            end else begin
                chk("d4_latency", ov4, 0);
            end
        end
        @(negedge clk);
        iv4 = 1'b0;
        #1;
        chk("d4_drained", ov4, 0);

        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            iv = (c < 9);
            if (c < 9) din = tab16[c].din;
            #1;
            if (c < 9) chk("d16_in_ready", ir, 1);
            if (c >= 4) begin
                chk("d16_out_valid", ov, 1);
                chk("d16_code", code, tab16[c-4].code);
                chk("d16_err", rerr, tab16[c-4].err);
            end else begin
                chk("d16_latency", ov, 0);
            end
        end
        @(negedge clk);
        iv = 1'b0;
        #1;
        chk("d16_drained", ov, 0);

        begin
            int sent = 0;
            ordy = 1'b0;
            for (int c = 0; c < 9; c++) begin
                @(negedge clk);
                iv  = 1'b1;
                din = 12'(bp_vals[sent]);
                #1;
                if (c >= 4) begin
                    chk("bp_in_ready", ir, 0);
                    chk("bp_out_valid", ov, 1);
                    chk("bp_code_hold", code, 16'h001C);
                    chk("bp_err_hold", rerr, 0);
                end
                if (iv && ir) sent++;
            end
            chk("bp_accepted", sent, 4);
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                iv   = 1'b0;
                ordy = 1'b1;
                #1;
                if (c < 4) begin
                    chk("bp_rel_valid", ov, 1);
                    chk("bp_rel_order", weight(code), bp_vals[c]);
                end else begin
                    chk("bp_rel_empty", ov, 0);
                end
            end
        end

        @(negedge clk);
        iv = 1'b1; din = 12'd100;
        #1;
        chk("mid_rst_accept0", ir, 1);
        @(negedge clk);
        din = 12'd200;
        #1;
        chk("mid_rst_accept1", ir, 1);
        @(negedge clk);
        iv = 1'b0; rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", ir, 0);
        @(negedge clk);
        #1;
        chk("mid_rst_out_valid", ov, 0);
        chk("mid_rst_code", code, 0);
        chk("mid_rst_err", rerr, 0);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_release_ready", ir, 1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            chk("flushed_token", ov, 0);
        end

        stream16(2584, 100, 100, 1'b1);
        stream16(10000, 50, 50, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
